vga_capture: RTL
================

# vga_capture

Sink-side counterpart of the VGA timing generator: samples a VGA pixel stream (hsync, vsync, blank_n, 8-bit R/G/B) on the pixel clock and rebuilds the pixel coordinates. Writes every active pixel into a frame-buffer write port with the same {v_addr, h_addr} addressing the video memory uses. Checks each frame's geometry. Used for loopback checks of the display path and as a capture front-end for a second frame buffer.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_AW, 10, horizontal address width
- V_AW, 9, vertical address width

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-low reset
- vga_hsync  in  1  horizontal sync, active-low pulse
- vga_vsync  in  1  vertical sync, active-low pulse
- vga_blank_n  in  1  high = active pixel
- vga_r, vga_g, vga_b  in  8 each  pixel colour
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  V_AW+H_AW  {v_cnt[V_AW-1:0], h_cnt[H_AW-1:0]}
- wr_data  out  24  {R,G,B}
- locked  out  1  high once the first frame start has been seen
- frame_done  out  1  one-cycle pulse at each frame start while locked
- frame_err  out  1  valid only with frame_done; high = previous frame geometry wrong
- frame_cnt  out  16  count of error-free frames; wraps at 16'hFFFF -> 0

## Operation
- Input stage: all VGA inputs are registered once (stage S1). Falling edges of hsync and vsync are detected between S1 and the previous S1 value.
- FSM states:
  - IDLE: entered at reset. No writes.
  - LOCKED: entered on the first vsync falling edge. Leaves only via reset.
- Frame start (vsync falling edge):
  - h_cnt, v_cnt and line_err are cleared.
  - In LOCKED: frame_done pulses. frame_err = line_err | (v_cnt != V_ACTIVE), using values before the clear. frame_cnt increments when frame_err = 0.
  - IDLE -> LOCKED transition: no frame_done.
- Line start (hsync falling edge): h_cnt cleared.
- Active pixel (S1 blank_n high, LOCKED):
  - Write issued when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - h_cnt increments and saturates at H_ACTIVE. Extra pixels are dropped and set line_err.
- End of active line (blank_n falling edge in S1):
  - h_cnt != H_ACTIVE sets line_err.
  - v_cnt increments, saturating at V_ACTIVE. Extra lines set line_err.
- Simultaneous events:
  - vsync and hsync falling in the same cycle: treated as frame start; both counters are cleared.
  - blank_n high in a frame-start cycle: the pixel is written at (0,0) and h_cnt becomes 1.
- Lines with no active pixels (vertical blanking) do not change v_cnt.

## Timing
- Latency: a pixel presented at the inputs in cycle N appears on wr_en/wr_addr/wr_data in cycle N+2 (S1 register plus output register).
- frame_done/frame_err are registered. They assert 2 cycles after vsync falls at the input.
- Reset values, all outputs: wr_en 0, wr_addr 0, wr_data 0, locked 0, frame_done 0, frame_err 0, frame_cnt 0. All internal counters, line_err and S1 registers are 0; S1 syncs reset to 1 (idle-high).
- Reset asserted mid-frame: outputs go to reset values immediately. After release, the block re-enters IDLE and ignores the stream until the next vsync falling edge.
- wr_en is a single-cycle strobe per pixel. There is no backpressure; the frame-buffer port must accept one write per clock.

## Structure
- Shared package vga_pkg:
  - H_ACTIVE/V_ACTIVE defaults and H_AW/V_AW, shared with the timing generator and vmem.
  - FSM state typedef {IDLE, LOCKED}.
- Sub-module vga_edge_det: S1 register plus previous-value register. Outputs registered signals and falling-edge pulses. Instantiated once for the sync/blank bundle.
- Counters, FSM, error logic and the output register live in vga_capture.

## Test plan
- Reset, then 3 well-formed 640x480 frames from the reference generator -> locked rises at the first vsync edge. 2 frame_done pulses with frame_err=0; frame_cnt=2. Exactly 307200 writes per full frame; first write addr 0, last addr {9'd479,10'd639}.
- Pixel (x=5, y=7) driven as 24'h12_34_56 -> write of wr_addr={9'd7,10'd5}, wr_data=24'h123456 exactly 2 cycles after input.
- One line with 641 active pixels -> pixel 641 not written; next frame_done has frame_err=1; frame_cnt unchanged.
- Frame with only 479 active lines -> frame_err=1 at the following frame_done. Next good frame -> frame_err=0 and frame_cnt increments.
- Reset asserted at line 200 of a frame -> wr_en drops at once. No writes until the next vsync falling edge; the following full frame reports frame_err=0.
- hsync and vsync falling together with blank_n high -> write at addr 0; frame_done pulses; counters restart cleanly.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry defaults and capture FSM state type
package vga_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_H_AW = 10;
  localparam int VGA_V_AW = 9;
  typedef enum logic {IDLE, LOCKED} cap_state_t;
endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: input register stage (S1) plus previous-value register with falling-edge pulses
// ports: clk, rst (async active-low), d (raw inputs), q (S1 value), fall (S1 low while previous S1 high)
module vga_edge_det #(
  parameter int W = 3,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] fall
);
  logic [W-1:0] prev;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= INIT;
      prev <= INIT;
    end else begin
      q <= d;
      prev <= q;
    end
  assign fall = prev & ~q;
endmodule

// File: rtl/vga_capture.sv
// vga_capture: rebuilds pixel coordinates from a VGA stream, writes active pixels, checks frame geometry
// ports: clk, rst (async active-low); vga_* stream in; wr_en/wr_addr/wr_data frame-buffer write;
//        locked, frame_done, frame_err (with frame_done), frame_cnt (error-free frames)
module vga_capture import vga_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int H_AW = VGA_H_AW,
  parameter int V_AW = VGA_V_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vga_hsync,
  input  logic                 vga_vsync,
  input  logic                 vga_blank_n,
  input  logic [7:0]           vga_r,
  input  logic [7:0]           vga_g,
  input  logic [7:0]           vga_b,
  output logic                 wr_en,
  output logic [V_AW+H_AW-1:0] wr_addr,
  output logic [23:0]          wr_data,
  output logic                 locked,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt
);
  localparam logic [H_AW-1:0] H_MAX = H_AW'(H_ACTIVE);
  localparam logic [V_AW-1:0] V_MAX = V_AW'(V_ACTIVE);
  logic [2:0] s1, fl;
  logic [23:0] rgb_s1;
  cap_state_t state;
  logic [H_AW-1:0] h_cnt, h_eff;
  logic [V_AW-1:0] v_cnt, v_eff;
  logic line_err, hs_fall, vs_fall, bl, bl_fall, run, pix, h_ok, v_ok, geo_err, eol;
  // syncs idle high, blank_n idles low
  vga_edge_det #(.W(3), .INIT(3'b110)) u_edge (
    .clk(clk), .rst(rst), .d({vga_hsync, vga_vsync, vga_blank_n}), .q(s1), .fall(fl)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) rgb_s1 <= '0;
    else rgb_s1 <= {vga_r, vga_g, vga_b};
  // counters as seen by the current S1 pixel: frame start wins over line start
  always_comb begin
    hs_fall = fl[2];
    vs_fall = fl[1];
    bl = s1[0];
    bl_fall = fl[0];
    h_eff = (vs_fall || hs_fall) ? '0 : h_cnt;
    v_eff = vs_fall ? '0 : v_cnt;
    run = state == LOCKED || vs_fall;
    pix = run && bl;
    h_ok = h_eff < H_MAX;
    v_ok = v_eff < V_MAX;
    geo_err = line_err || v_cnt != V_MAX;
    eol = bl_fall && !vs_fall;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      line_err <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      locked <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      wr_en <= pix && h_ok && v_ok;
      wr_addr <= {v_eff, h_eff};
      wr_data <= rgb_s1;
      frame_done <= vs_fall && state == LOCKED;
      frame_err <= vs_fall && state == LOCKED && geo_err;
      if (vs_fall) begin
        state <= LOCKED;
        locked <= 1'b1;
        if (state == LOCKED && !geo_err) frame_cnt <= frame_cnt + 16'd1;
      end
      if (run) begin
        h_cnt <= (pix && h_ok) ? h_eff + 1'b1 : h_eff;
        v_cnt <= (eol && v_cnt != V_MAX) ? v_cnt + 1'b1 : v_eff;
        line_err <= (line_err && !vs_fall) || (pix && !h_ok) || (eol && (h_cnt != H_MAX || v_cnt == V_MAX));
      end
    end
endmodule
